// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache controller's wait/beat counter:
// terminal-mode codes, the counter state encoding and a parameter sanity helper.
package cache_ctrl_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;
  localparam int MODE_ONESHOT  = 2;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } wait_state_t;

  function automatic bit params_valid(input int width, input int mode);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (mode >= MODE_WRAP) && (mode <= MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/cache_wait_counter.sv
// Wait/beat counter: times memory latency and counts refill/write-back beats,
// with a run-time terminal count, load/clear controls and a one-cycle Done pulse.
module cache_wait_counter
  import cache_ctrl_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int MODE            = 0,
  parameter int HOLD_ON_DISABLE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             Clear,
  input  logic             LoadEn,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic [WIDTH-1:0] TermVal,
  output logic [WIDTH-1:0] Count,
  output logic             AtTerm,
  output logic             Done,
  output logic             Busy
);

  if (!params_valid(WIDTH, MODE)) begin : g_param_error
    $error("cache_wait_counter: WIDTH must be 1..16 and MODE 0..2");
  end

  localparam bit HOLD_EN = (HOLD_ON_DISABLE != 0);

  wait_state_t      state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] term_reg, term_next;
  logic             done_reg, done_next;
  logic             busy_reg;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_disabled;
  logic             at_term;

  assign count_inc      = count_reg + WIDTH'(1);
  assign count_disabled = HOLD_EN ? count_reg : '0;
  assign at_term        = (count_reg == term_reg);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    term_next  = term_reg;
    done_next  = 1'b0;

    if (Clear) begin
      count_next = '0;
      state_next = ST_IDLE;
    end else if (LoadEn) begin
      // A load re-latches the terminal and may itself land on it.
      count_next = LoadVal;
      term_next  = TermVal;
      done_next  = (LoadVal == TermVal);
      state_next = Enable ? ST_COUNT : ST_IDLE;
    end else if (Enable) begin
      unique case (state_reg)
        ST_IDLE: begin
          term_next  = TermVal;
          state_next = ST_COUNT;
          if (count_reg == TermVal) begin
            done_next = 1'b1;
          end else begin
            count_next = count_inc;
            done_next  = (count_inc == TermVal);
          end
        end
        ST_COUNT: begin
          if (!at_term) begin
            count_next = count_inc;
            done_next  = (count_inc == term_reg);
          end else if (MODE == MODE_SATURATE) begin
            state_next = ST_HOLD;
          end else if (MODE == MODE_ONESHOT) begin
            count_next = '0;
            state_next = ST_HOLD;
          end else begin
            // Wrapping onto a zero terminal is itself a terminal hit.
            count_next = '0;
            done_next  = (term_reg == '0);
          end
        end
        ST_HOLD: begin
          state_next = ST_HOLD;
        end
        default: begin
          count_next = '0;
          state_next = ST_IDLE;
        end
      endcase
    end else begin
      count_next = count_disabled;
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      term_reg  <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      term_reg  <= term_next;
      done_reg  <= done_next;
      busy_reg  <= (state_next == ST_COUNT);
    end
  end

  assign Count  = count_reg;
  assign AtTerm = at_term;
  assign Done   = done_reg;
  assign Busy   = busy_reg;

endmodule

// File: tb/tb_cache_wait_counter.sv
// Five counter configurations driven from shared inputs, checked against a
// rule-level model, a directed vector table and hand-written reset sequences.
module tb_cache_wait_counter;

  localparam int NDUT = 5;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_HOLD = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b0, clear = 1'b0, load_en = 1'b0;
  logic [3:0] load_val = '0, term_val = '0;

  logic [1:0] count0, count3;
  logic [2:0] count1;
  logic [3:0] count2, count4;
  logic [NDUT-1:0] at_v, done_v, busy_v;
  logic [15:0] act_count [NDUT];

  always #5 CLK = ~CLK;

  cache_wait_counter #(.WIDTH(2), .MODE(0), .HOLD_ON_DISABLE(0)) u_d0 (
    .CLK(CLK), .RST(RST), .Enable(enable), .Clear(clear), .LoadEn(load_en),
    .LoadVal(load_val[1:0]), .TermVal(term_val[1:0]), .Count(count0),
    .AtTerm(at_v[0]), .Done(done_v[0]), .Busy(busy_v[0]));
  cache_wait_counter #(.WIDTH(3), .MODE(1), .HOLD_ON_DISABLE(0)) u_d1 (
    .CLK(CLK), .RST(RST), .Enable(enable), .Clear(clear), .LoadEn(load_en),
    .LoadVal(load_val[2:0]), .TermVal(term_val[2:0]), .Count(count1),
    .AtTerm(at_v[1]), .Done(done_v[1]), .Busy(busy_v[1]));
  cache_wait_counter #(.WIDTH(4), .MODE(2), .HOLD_ON_DISABLE(0)) u_d2 (
    .CLK(CLK), .RST(RST), .Enable(enable), .Clear(clear), .LoadEn(load_en),
    .LoadVal(load_val), .TermVal(term_val), .Count(count2),
    .AtTerm(at_v[2]), .Done(done_v[2]), .Busy(busy_v[2]));
  cache_wait_counter #(.WIDTH(2), .MODE(0), .HOLD_ON_DISABLE(1)) u_d3 (
    .CLK(CLK), .RST(RST), .Enable(enable), .Clear(clear), .LoadEn(load_en),
    .LoadVal(load_val[1:0]), .TermVal(term_val[1:0]), .Count(count3),
    .AtTerm(at_v[3]), .Done(done_v[3]), .Busy(busy_v[3]));
  cache_wait_counter #(.WIDTH(4), .MODE(1), .HOLD_ON_DISABLE(1)) u_d4 (
    .CLK(CLK), .RST(RST), .Enable(enable), .Clear(clear), .LoadEn(load_en),
    .LoadVal(load_val), .TermVal(term_val), .Count(count4),
    .AtTerm(at_v[4]), .Done(done_v[4]), .Busy(busy_v[4]));

  assign act_count[0] = {14'b0, count0};
  assign act_count[1] = {13'b0, count1};
  assign act_count[2] = {12'b0, count2};
  assign act_count[3] = {14'b0, count3};
  assign act_count[4] = {12'b0, count4};

  int cfg_width [NDUT] = '{2, 3, 4, 2, 4};
  int cfg_mode  [NDUT] = '{0, 1, 2, 0, 1};
  int cfg_hold  [NDUT] = '{0, 0, 0, 1, 1};

  int m_count [NDUT];
  int m_term  [NDUT];
  int m_phase [NDUT];
  bit m_done  [NDUT];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_count[k] = 0; m_term[k] = 0; m_phase[k] = PH_IDLE; m_done[k] = 1'b0;
    end
  endtask

  // Rule-level view of one clock edge for configuration k.
  task automatic model_edge(input int k);
    int mask, tv, lv;
    mask = (1 << cfg_width[k]) - 1;
    tv = int'(term_val) & mask;
    lv = int'(load_val) & mask;
    m_done[k] = 1'b0;
    if (clear) begin
      m_count[k] = 0;
      m_phase[k] = PH_IDLE;
    end else if (load_en) begin
      m_count[k] = lv;
      m_term[k]  = tv;
      m_done[k]  = (lv == tv);
      m_phase[k] = enable ? PH_RUN : PH_IDLE;
    end else if (enable) begin
      if (m_phase[k] == PH_IDLE) begin
        m_term[k] = tv;
        m_phase[k] = PH_RUN;
        if (m_count[k] == tv) m_done[k] = 1'b1;
        else begin
          m_count[k] = (m_count[k] + 1) & mask;
          m_done[k] = (m_count[k] == tv);
        end
      end else if (m_phase[k] == PH_RUN) begin
        if (m_count[k] != m_term[k]) begin
          m_count[k] = (m_count[k] + 1) & mask;
          m_done[k] = (m_count[k] == m_term[k]);
        end else if (cfg_mode[k] == 0) begin
          m_count[k] = 0;
          m_done[k] = (m_term[k] == 0);
        end else if (cfg_mode[k] == 1) begin
          m_phase[k] = PH_HOLD;
        end else begin
          m_count[k] = 0;
          m_phase[k] = PH_HOLD;
        end
      end
    end else begin
      if (cfg_hold[k] == 0) m_count[k] = 0;
      m_phase[k] = PH_IDLE;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("d%0d count", k), int'(act_count[k]), m_count[k]);
      chk($sformatf("d%0d done", k), int'(done_v[k]), int'(m_done[k]));
      chk($sformatf("d%0d busy", k), int'(busy_v[k]), (m_phase[k] == PH_RUN) ? 1 : 0);
      chk($sformatf("d%0d at_term", k), int'(at_v[k]), (m_count[k] == m_term[k]) ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < NDUT; k++) model_edge(k);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit en, input bit clr, input bit ld, input int lv, input int tv);
    enable = en; clear = clr; load_en = ld;
    load_val = 4'(lv); term_val = 4'(tv);
  endtask

  typedef struct {
    int dut;
    bit en, clr, ld;
    int lv, tv;
    int e_count, e_done, e_busy, e_at;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int dut, input bit en, input bit clr, input bit ld,
                     input int lv, input int tv, input int ec, input int ed,
                     input int eb, input int ea);
    vec_t v;
    v.dut = dut; v.en = en; v.clr = clr; v.ld = ld; v.lv = lv; v.tv = tv;
    v.e_count = ec; v.e_done = ed; v.e_busy = eb; v.e_at = ea;
    vecs.push_back(v);
  endtask

  initial begin
    // WRAP, width 2, terminal 3
    add(0, 0, 1, 0, 0, 3, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 3, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 3, 2, 0, 1, 0);
    add(0, 1, 0, 0, 0, 3, 3, 1, 1, 1);
    add(0, 1, 0, 0, 0, 3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 3, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 3, 2, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
    // SATURATE, width 3, terminal 2
    add(1, 0, 1, 0, 0, 2, 0, 0, 0, -1);
    add(1, 1, 0, 0, 0, 2, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 2, 2, 1, 1, 1);
    add(1, 1, 0, 0, 0, 2, 2, 0, 0, 1);
    add(1, 1, 0, 0, 0, 2, 2, 0, 0, 1);
    add(1, 1, 0, 0, 0, 2, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    // ONESHOT, width 4, terminal 5
    add(2, 0, 1, 0, 0, 5, 0, 0, 0, -1);
    add(2, 1, 0, 0, 0, 5, 1, 0, 1, 0);
    add(2, 1, 0, 0, 0, 5, 2, 0, 1, 0);
    add(2, 1, 0, 0, 0, 5, 3, 0, 1, 0);
    add(2, 1, 0, 0, 0, 5, 4, 0, 1, 0);
    add(2, 1, 0, 0, 0, 5, 5, 1, 1, 1);
    add(2, 1, 0, 0, 0, 5, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 5, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 5, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 5, 1, 0, 1, 0);
    // Clear beats load and enable; then a load that lands on the terminal
    add(0, 1, 1, 1, 2, 3, 0, 0, 0, -1);
    add(0, 0, 0, 1, 2, 2, 2, 1, 0, 1);
    // Hold-on-disable, WRAP, terminal 3
    add(3, 0, 1, 0, 0, 3, 0, 0, 0, -1);
    add(3, 1, 0, 0, 0, 3, 1, 0, 1, 0);
    add(3, 1, 0, 0, 0, 3, 2, 0, 1, 0);
    add(3, 0, 0, 0, 0, 3, 2, 0, 0, 0);
    add(3, 1, 0, 0, 0, 3, 3, 1, 1, 1);

    model_reset();
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    $display("reset asserted, checking reset state");
    compare_all();
    for (int k = 0; k < NDUT; k++) chk($sformatf("reset d%0d count", k), int'(act_count[k]), 0);
    RST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].tv);
      tick();
      $display("vec %0d dut%0d en=%0b clr=%0b ld=%0b lv=%0d tv=%0d count=%0d done=%0b busy=%0b",
               i, vecs[i].dut, vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].tv,
               act_count[vecs[i].dut], done_v[vecs[i].dut], busy_v[vecs[i].dut]);
      chk($sformatf("vec%0d count", i), int'(act_count[vecs[i].dut]), vecs[i].e_count);
      chk($sformatf("vec%0d done", i), int'(done_v[vecs[i].dut]), vecs[i].e_done);
      chk($sformatf("vec%0d busy", i), int'(busy_v[vecs[i].dut]), vecs[i].e_busy);
      if (vecs[i].e_at >= 0)
        chk($sformatf("vec%0d at_term", i), int'(at_v[vecs[i].dut]), vecs[i].e_at);
    end

    // Asynchronous reset mid-count, with no clock edge in between
    drive(0, 1, 0, 0, 15);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 0, 15);
      tick();
    end
    $display("seq async_reset pre count=%0d busy=%0b", count2, busy_v[2]);
    chk("async pre count", int'(count2), 7);
    #2 RST = 1'b0;
    model_reset();
    #1;
    $display("seq async_reset asserted count=%0d done=%0b busy=%0b", count2, done_v[2], busy_v[2]);
    chk("async count", int'(count2), 0);
    chk("async done", int'(done_v[2]), 0);
    chk("async busy", int'(busy_v[2]), 0);
    #1 RST = 1'b1;
    tick();
    $display("seq async_reset released count=%0d", count2);
    chk("async restart count", int'(count2), 1);

    // Terminal zero under WRAP: every enabled edge is a terminal hit
    drive(0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
      $display("seq term0 %0d count=%0d done=%0b", i, count0, done_v[0]);
      chk("term0 done", int'(done_v[0]), 1);
      chk("term0 count", int'(count0), 0);
    end

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)));
      tick();
      $display("rnd %0d en=%0b clr=%0b ld=%0b lv=%0d tv=%0d counts=%0d,%0d,%0d,%0d,%0d done=%b",
               i, enable, clear, load_en, load_val, term_val,
               count0, count1, count2, count3, count4, done_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
